ras_ctrl: RTL and testbench
===========================

# ras_ctrl

Return address stack (RAS) for the fetch-stage branch predictor. It holds up to RAS_DEPTH truncated return targets (RAS_TARGET_WIDTH bits, same width as the BTB target field) in a circular buffer. It pushes on predicted calls and pops on predicted returns, and exposes its top-of-stack pointer and occupancy so fetch can checkpoint them per branch. On a mispredict the backend restores the checkpoint; this block applies that restore with highest priority.

## Interface
Parameters:
- RAS_DEPTH, 8, number of entries; must be a power of 2, at least 2
- RAS_TARGET_WIDTH, 12, stored target width; upper PC bits come from the upper-PC table outside this block
- LOG_RAS_DEPTH, $clog2(RAS_DEPTH), pointer width

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- nRST  in  1  reset, asynchronous, active-low
- push_valid  in  1  predicted call this cycle
- push_target  in  RAS_TARGET_WIDTH  return target to push
- pop_valid  in  1  predicted return this cycle
- top_target  out  RAS_TARGET_WIDTH  entry at ras_index; combinational from registered state
- top_valid  out  1  ras_count != 0
- ras_index  out  LOG_RAS_DEPTH  current top pointer (registered), for checkpointing
- ras_count  out  LOG_RAS_DEPTH+1  current occupancy, 0..RAS_DEPTH (registered), for checkpointing
- restore_valid  in  1  mispredict restore
- restore_index  in  LOG_RAS_DEPTH  checkpointed pointer
- restore_count  in  LOG_RAS_DEPTH+1  checkpointed occupancy, at most RAS_DEPTH
- restore_target  in  RAS_TARGET_WIDTH  checkpointed top entry; used only under RAS_RESTORE_WRITE_EN

## Operation
- State: entry array [RAS_DEPTH], ras_index, ras_count.
- Reset (async assert): all entries 0, ras_index 0, ras_count 0, so top_target 0 and top_valid 0.
- Priority order: restore, then push+pop, then push, then pop, then idle.
- Restore: ras_index <= restore_index and ras_count <= restore_count. push_valid and pop_valid are ignored that cycle. With RAS_RESTORE_WRITE_EN, entry[restore_index] <= restore_target.
- Push only: ras_index <= ras_index+1 (mod RAS_DEPTH), entry[ras_index+1] <= push_target, ras_count <= min(ras_count+1, RAS_DEPTH).
  - When the stack is full, the oldest entry is overwritten silently; ras_count stays at RAS_DEPTH.
- Pop only, ras_count > 0: ras_index <= ras_index-1 (mod RAS_DEPTH), ras_count <= ras_count-1. Entries are unchanged.
- Pop only, ras_count == 0: no state change. top_target still presents the stale entry; the consumer treats it as a prediction with top_valid=0.
- Push and pop together (return followed by call in the same fetch block): entry[ras_index] <= push_target. ras_index is unchanged. ras_count <= max(ras_count, 1).
- Pointer arithmetic wraps naturally in LOG_RAS_DEPTH bits.

## Timing
- top_target and top_valid reflect state as of the last edge. The pop consumer uses the pre-pop top_target in the same cycle it asserts pop_valid.
- All updates are visible one cycle after the request edge; there is zero-cycle read latency, one-cycle update latency.
- There is no internal bypass. A push's target appears on top_target in the following cycle.
- restore_valid may be asserted on consecutive cycles; each cycle's restore applies.
- Reset asserted mid-operation clears state immediately; pending requests are dropped.

## Configuration
- RAS_RESTORE_WRITE_EN defined: restore also writes restore_target into entry[restore_index]. This repairs a top entry that wrong-path pushes overwrote.
- Not defined: restore updates only the pointer and count; restore_target is unused and the entries are untouched.

## Test plan
- Reset, then push 0x111, 0x222, 0x333 on consecutive cycles -> ras_index=3, ras_count=3, top_target=0x333. Then pop three times -> top_target 0x333, 0x222, 0x111 on the pop cycles; ras_count ends at 0, top_valid=0.
- Push 9 distinct targets (RAS_DEPTH=8) -> ras_count saturates at 8 and ras_index wraps to 1. Eight pops return targets 9..2; the first target is lost.
- Pop on empty after reset -> ras_index=0, ras_count=0 unchanged, top_target=0.
- Push+pop in the same cycle with count=2 and top=0xAAA, push_target=0xBBB -> top_target=0xBBB, ras_index and ras_count unchanged. The same from empty -> ras_count=1.
- Checkpoint index=2, count=2, top=0x222; push 0x555; then restore (restore_target=0x222) with push_valid=1 in the same cycle -> ras_index=2, ras_count=2, push ignored. With the macro, top_target=0x222; without it, top_target=0x222 as well, since the entry at index 2 was not overwritten.
- With RAS_RESTORE_WRITE_EN: checkpoint index=2/top=0x222; pop, then push 0x999 (overwrites entry 2); then restore with restore_target=0x222 -> top_target=0x222. Without the macro -> top_target=0x999.

Source files
------------

// File: rtl/ras_ctrl.sv
// Return address stack: circular buffer of truncated return targets with
// checkpoint restore. Optional macro RAS_RESTORE_WRITE_EN also repairs the restored top entry.
module ras_ctrl #(
  parameter int RAS_DEPTH        = 8,
  parameter int RAS_TARGET_WIDTH = 12,
  parameter int LOG_RAS_DEPTH    = $clog2(RAS_DEPTH)
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        push_valid,
  input  logic [RAS_TARGET_WIDTH-1:0] push_target,
  input  logic                        pop_valid,
  output logic [RAS_TARGET_WIDTH-1:0] top_target,
  output logic                        top_valid,
  output logic [LOG_RAS_DEPTH-1:0]    ras_index,
  output logic [LOG_RAS_DEPTH:0]      ras_count,
  input  logic                        restore_valid,
  input  logic [LOG_RAS_DEPTH-1:0]    restore_index,
  input  logic [LOG_RAS_DEPTH:0]      restore_count,
  input  logic [RAS_TARGET_WIDTH-1:0] restore_target
);

  localparam logic [LOG_RAS_DEPTH:0] COUNT_FULL = (LOG_RAS_DEPTH+1)'(RAS_DEPTH);

  logic [RAS_TARGET_WIDTH-1:0] r_entries [RAS_DEPTH];
  logic [LOG_RAS_DEPTH-1:0]    r_index;
  logic [LOG_RAS_DEPTH:0]      r_count;

  logic [LOG_RAS_DEPTH-1:0]    w_next_index;
  logic [LOG_RAS_DEPTH:0]      w_next_count;
  logic                        w_wr_en;
  logic [LOG_RAS_DEPTH-1:0]    w_wr_addr;
  logic [RAS_TARGET_WIDTH-1:0] w_wr_data;

  // Restore wins over everything; push+pop replaces the top in place.
  always_comb begin
    w_next_index = r_index;
    w_next_count = r_count;
    w_wr_en      = 1'b0;
    w_wr_addr    = r_index;
    w_wr_data    = push_target;
    if (restore_valid) begin
      w_next_index = restore_index;
      w_next_count = restore_count;
`ifdef RAS_RESTORE_WRITE_EN
      w_wr_en      = 1'b1;
      w_wr_addr    = restore_index;
      w_wr_data    = restore_target;
`endif
    end else if (push_valid && pop_valid) begin
      w_wr_en = 1'b1;
      if (r_count == '0) begin
        w_next_count = (LOG_RAS_DEPTH+1)'(1);
      end
    end else if (push_valid) begin
      w_next_index = r_index + 1'b1;
      w_wr_en      = 1'b1;
      w_wr_addr    = r_index + 1'b1;
      if (r_count != COUNT_FULL) begin
        w_next_count = r_count + 1'b1;
      end
    end else if (pop_valid && (r_count != '0)) begin
      w_next_index = r_index - 1'b1;
      w_next_count = r_count - 1'b1;
    end
  end

`ifndef RAS_RESTORE_WRITE_EN
  logic w_unused_restore_target;
  assign w_unused_restore_target = ^restore_target;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_index <= '0;
      r_count <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        r_entries[i] <= '0;
      end
    end else begin
      r_index <= w_next_index;
      r_count <= w_next_count;
      if (w_wr_en) begin
        r_entries[w_wr_addr] <= w_wr_data;
      end
    end
  end

  assign top_target = r_entries[r_index];
  assign top_valid  = (r_count != '0);
  assign ras_index  = r_index;
  assign ras_count  = r_count;

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed self-checking bench for ras_ctrl (RAS_DEPTH=8, 12-bit targets).
// Expectations follow RAS_RESTORE_WRITE_EN when the bench is built with it.
module tb_ras_ctrl;

  logic        CLK;
  logic        nRST;
  logic        push_valid;
  logic [11:0] push_target;
  logic        pop_valid;
  logic [11:0] top_target;
  logic        top_valid;
  logic [2:0]  ras_index;
  logic [3:0]  ras_count;
  logic        restore_valid;
  logic [2:0]  restore_index;
  logic [3:0]  restore_count;
  logic [11:0] restore_target;

  int vectorCount = 0;
  int missCount   = 0;

  ras_ctrl #(.RAS_DEPTH(8), .RAS_TARGET_WIDTH(12)) dut (
    .CLK(CLK), .nRST(nRST),
    .push_valid(push_valid), .push_target(push_target), .pop_valid(pop_valid),
    .top_target(top_target), .top_valid(top_valid),
    .ras_index(ras_index), .ras_count(ras_count),
    .restore_valid(restore_valid), .restore_index(restore_index),
    .restore_count(restore_count), .restore_target(restore_target)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic applyStimulus(input logic push, input logic [11:0] tgt, input logic pop,
                               input logic rst, input logic [2:0] ri, input logic [3:0] rc,
                               input logic [11:0] rt);
    push_valid     = push;
    push_target    = tgt;
    pop_valid      = pop;
    restore_valid  = rst;
    restore_index  = ri;
    restore_count  = rc;
    restore_target = rt;
    @(posedge CLK);
    #1;
    push_valid    = 1'b0;
    pop_valid     = 1'b0;
    restore_valid = 1'b0;
  endtask

  task automatic doPush(input logic [11:0] tgt);
    applyStimulus(1'b1, tgt, 1'b0, 1'b0, 3'd0, 4'd0, 12'h0);
  endtask

  task automatic doPop();
    applyStimulus(1'b0, 12'h0, 1'b1, 1'b0, 3'd0, 4'd0, 12'h0);
  endtask

  task automatic doReset();
    @(negedge CLK);
    nRST = 1'b0;
    #3;
    nRST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkState(input string tag, input logic [2:0] idx, input logic [3:0] cnt,
                            input logic [11:0] top);
    checkOutput({tag, ".index"}, 32'(ras_index), 32'(idx));
    checkOutput({tag, ".count"}, 32'(ras_count), 32'(cnt));
    checkOutput({tag, ".top"}, 32'(top_target), 32'(top));
    checkOutput({tag, ".valid"}, 32'(top_valid), 32'(cnt != 4'd0));
  endtask

  initial begin
    nRST = 1'b0;
    push_valid = 1'b0; push_target = '0; pop_valid = 1'b0;
    restore_valid = 1'b0; restore_index = '0; restore_count = '0; restore_target = '0;
    #12;
    checkState("reset", 3'd0, 4'd0, 12'h000);
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    doPop();
    checkState("pop_empty", 3'd0, 4'd0, 12'h000);

    doPush(12'h111);
    doPush(12'h222);
    doPush(12'h333);
    checkState("push3", 3'd3, 4'd3, 12'h333);
    checkOutput("pop1.top", 32'(top_target), 32'h333);
    doPop();
    checkOutput("pop2.top", 32'(top_target), 32'h222);
    doPop();
    checkOutput("pop3.top", 32'(top_target), 32'h111);
    doPop();
    checkOutput("pop3.count", 32'(ras_count), 32'd0);
    checkOutput("pop3.valid", 32'(top_valid), 32'd0);

    doReset();
    for (int i = 1; i <= 9; i++) doPush(12'h100 + 12'(i));
    checkState("push9", 3'd1, 4'd8, 12'h109);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("wrap_pop%0d", k), 32'(top_target), 32'h109 - 32'(k));
      doPop();
    end
    checkOutput("wrap_end.count", 32'(ras_count), 32'd0);
    checkOutput("wrap_end.index", 32'(ras_index), 32'd1);

    doReset();
    doPush(12'h123);
    doPush(12'hAAA);
    applyStimulus(1'b1, 12'hBBB, 1'b1, 1'b0, 3'd0, 4'd0, 12'h0);
    checkState("pushpop", 3'd2, 4'd2, 12'hBBB);
    doPop();
    checkState("pushpop_below", 3'd1, 4'd1, 12'h123);

    doReset();
    applyStimulus(1'b1, 12'hCCC, 1'b1, 1'b0, 3'd0, 4'd0, 12'h0);
    checkState("pushpop_empty", 3'd0, 4'd1, 12'hCCC);

    doReset();
    doPush(12'h111);
    doPush(12'h222);
    checkState("ckpt", 3'd2, 4'd2, 12'h222);
    doPush(12'h555);
    checkState("wrongpath", 3'd3, 4'd3, 12'h555);
    applyStimulus(1'b1, 12'h777, 1'b0, 1'b1, 3'd2, 4'd2, 12'h222);
    checkState("restore1", 3'd2, 4'd2, 12'h222);

    doPop();
    doPush(12'h999);
    checkState("overwrite", 3'd2, 4'd2, 12'h999);
    applyStimulus(1'b0, 12'h0, 1'b1, 1'b1, 3'd2, 4'd2, 12'h222);
`ifdef RAS_RESTORE_WRITE_EN
    checkState("restore2", 3'd2, 4'd2, 12'h222);
`else
    checkState("restore2", 3'd2, 4'd2, 12'h999);
`endif
    applyStimulus(1'b0, 12'h0, 1'b0, 1'b1, 3'd1, 4'd1, 12'h111);
    checkState("restore3", 3'd1, 4'd1, 12'h111);

    doPush(12'h444);
    #2;
    nRST = 1'b0;
    #1;
    checkState("async_reset", 3'd0, 4'd0, 12'h000);
    nRST = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
